sha256_nonce_sched: RTL and testbench
=====================================

SHA256_NONCE_SCHED -- requirements
Module: sha256_nonce_sched

Interface
REQ-001 Parameter SHA_WAIT, default 0: extra settle cycles per hash pass, allowing a multicycle path through the combinational compressor.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle request to begin a scan; honoured only in IDLE or DONE.
REQ-005 abort  in  1  terminate the scan in progress.
REQ-006 midstate  in  8x32  header first-chunk digest, word 0 = A.
REQ-007 merkle_tail, timestamp, target_bits  in  32 each  header words 16..18.
REQ-008 nonce_start, nonce_end  in  32 each  inclusive scan range.
REQ-009 target_hi  in  32  acceptance threshold.
REQ-010 busy  out  1  scan in progress.
REQ-011 done  out  1  scan finished; held until the next accepted start.
REQ-012 found  out  1  qualifies found_nonce and found_hash while done=1.
REQ-013 found_nonce  out  32  winning nonce.
REQ-014 found_hash  out  8x32  second-pass digest of the winning nonce.
REQ-015 hash_count  out  32  nonces fully evaluated in the current scan; wraps modulo 2^32.

Function
REQ-016 States: IDLE, PASS1, PASS2, CHECK, DONE.
REQ-017 All inputs except start and abort are captured on accepted start; later input changes have no effect on the scan in progress.
REQ-018 On accepted start: nonce <= nonce_start, hash_count <= 0, found <= 0, done <= 0, busy <= 1, next state PASS1.
REQ-019 PASS1 drives the compressor as follows: digest=midstate; W0=merkle_tail; W1=timestamp; W2=target_bits; W3=byte-swapped nonce; W4=0x80000000; W5..W14=0; W15=640.
REQ-020 PASS2 drives the compressor as follows: digest=SHA-256 initial values H0..H7; W0..W7=registered PASS1 result; W8=0x80000000; W9..W14=0; W15=256.
REQ-021 Each pass lasts 1+SHA_WAIT cycles; the compressor output is registered on the last cycle of the pass.
REQ-022 CHECK lasts 1 cycle and increments hash_count.
REQ-023 Per-nonce cost is 3+2*SHA_WAIT cycles.
REQ-024 Match condition: byte-swapped PASS2 word 7 <= target_hi (unsigned).
REQ-025 On match: latch found_nonce and found_hash, found <= 1, go to DONE.
REQ-026 On no match with nonce == nonce_end: found <= 0, go to DONE.
REQ-027 On no match otherwise: nonce <= nonce+1 modulo 2^32, go to PASS1.
REQ-028 nonce_start > nonce_end scans through 0xFFFFFFFF to 0 and up to nonce_end.
REQ-029 nonce_start == nonce_end evaluates exactly one nonce.
REQ-030 0..0xFFFFFFFF evaluates all 2^32 nonces; hash_count reads 0 at completion.
REQ-031 abort in PASS1, PASS2 or CHECK forces DONE with found=0 on the next edge; hash_count keeps the completed-nonce count.
REQ-032 abort has priority over a match in the same cycle.
REQ-033 abort is ignored in IDLE and DONE.
REQ-034 start is ignored while busy=1.
REQ-035 start and abort asserted together in DONE: start wins.
REQ-036 In DONE: busy=0, done=1; outputs hold until the next accepted start.

Reset
REQ-037 rst asserted, including mid-scan: state=IDLE; busy, done and found = 0; found_nonce=0; found_hash=0; hash_count=0; internal nonce and pass registers = 0.
REQ-038 The first start is accepted on the first rising edge after rst deasserts.

Structure
REQ-039 A shared sha256 package holds H0..H7, K0..K63, the padding constants 0x80000000, 640 and 256, the state enum, and the byte-swap and round functions.
REQ-040 The block instantiates exactly one existing sha256_block sub-module, time-shared between PASS1 and PASS2 through a 2:1 input mux.
REQ-041 The block contains no other sub-modules.

Verification
REQ-042 Bitcoin genesis header (midstate from the C model), range 0x7C2BAC10..0x7C2BAC2F, target_hi=0 -> found=1; found_nonce=0x7C2BAC1D; found_hash word7=0; hash_count=14; done 42 cycles after start (SHA_WAIT=0).
REQ-043 Same header, range 0x7C2BAC1E..0x7C2BAC2F, target_hi=0 -> found=0; hash_count=18; done after 54 cycles.
REQ-044 Range 0xFFFFFFFE..0x00000001, target_hi=0 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 evaluated in that order; hash_count=4.
REQ-045 target_hi=0xFFFFFFFF -> found on nonce_start after 3 cycles; with SHA_WAIT=2 -> found after 7 cycles.
REQ-046 abort in PASS2 of the 5th nonce -> DONE next edge, found=0, hash_count=4; rst pulse mid-scan -> all outputs 0 asynchronously.
REQ-047 start pulsed while busy -> no effect; start in DONE -> new scan, done and found cleared.

Source files
------------

// File: rtl/sha256_nonce_sched_pkg.sv
// Shared SHA-256 constants, types and round helpers for the nonce scheduler.
package sha256_nonce_sched_pkg;

  typedef logic [31:0]       word_t;
  typedef logic [7:0][31:0]  digest_t;  // index 0 = A / H0
  typedef logic [15:0][31:0] block_t;   // index 0 = W0

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PASS1,
    ST_PASS2,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam word_t PAD_ONE   = 32'h8000_0000;
  localparam word_t LEN_PASS1 = 32'd640;
  localparam word_t LEN_PASS2 = 32'd256;

  localparam digest_t H_INIT = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(word_t x, int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t bswap32(word_t x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic word_t big_sigma0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One compression round on working state {a..h} = s[0..7].
  function automatic digest_t sha256_round(digest_t s, word_t k, word_t w);
    word_t t1;
    word_t t2;
    digest_t r;
    t1   = s[7] + big_sigma1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2   = big_sigma0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    r[0] = t1 + t2;
    r[1] = s[0];
    r[2] = s[1];
    r[3] = s[2];
    r[4] = s[3] + t1;
    r[5] = s[4];
    r[6] = s[5];
    r[7] = s[6];
    return r;
  endfunction

endpackage

// File: rtl/sha256_nonce_sched_if.sv
// Request/response bundle between a scan controller and the nonce scheduler.
interface sha256_nonce_sched_if;
  import sha256_nonce_sched_pkg::*;

  logic    start;
  logic    abort;
  digest_t midstate;
  word_t   merkle_tail;
  word_t   timestamp;
  word_t   target_bits;
  word_t   nonce_start;
  word_t   nonce_end;
  word_t   target_hi;
  logic    busy;
  logic    done;
  logic    found;
  word_t   found_nonce;
  digest_t found_hash;
  word_t   hash_count;

  modport master (
    output start, abort, midstate, merkle_tail, timestamp, target_bits,
           nonce_start, nonce_end, target_hi,
    input  busy, done, found, found_nonce, found_hash, hash_count
  );

  modport slave (
    input  start, abort, midstate, merkle_tail, timestamp, target_bits,
           nonce_start, nonce_end, target_hi,
    output busy, done, found, found_nonce, found_hash, hash_count
  );
endinterface

// File: rtl/sha256_nonce_sched_block.sv
// Fully combinational SHA-256 compression of one 512-bit block.
module sha256_block
  import sha256_nonce_sched_pkg::*;
(
  input  digest_t digest_in,
  input  block_t  block_in,
  output digest_t digest_out
);

  word_t   w [64];
  digest_t st;

  // Expand the message schedule, run 64 rounds, add the chaining value.
  always_comb begin
    for (int i = 0; i < 16; i++) w[i] = block_in[i];
    for (int i = 16; i < 64; i++) begin
      w[i] = small_sigma1(w[i-2]) + w[i-7] + small_sigma0(w[i-15]) + w[i-16];
    end
    st = digest_in;
    for (int i = 0; i < 64; i++) st = sha256_round(st, K[i], w[i]);
    for (int i = 0; i < 8; i++) digest_out[i] = digest_in[i] + st[i];
  end

endmodule

// File: rtl/sha256_nonce_sched.sv
// Double-SHA-256 nonce scanner: one shared compressor, PASS1 -> PASS2 -> CHECK per nonce.
module sha256_nonce_sched
  import sha256_nonce_sched_pkg::*;
#(
  parameter int unsigned SHA_WAIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  sha256_nonce_sched_if.slave   bus
);

  localparam int unsigned WAIT_W = (SHA_WAIT > 0) ? $clog2(SHA_WAIT + 1) : 1;

  typedef struct packed {
    digest_t midstate;
    word_t   merkle_tail;
    word_t   timestamp;
    word_t   target_bits;
    word_t   nonce_end;
    word_t   target_hi;
  } cfg_t;

  state_t            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  word_t             nonce_q, nonce_d;
  digest_t           pass1_q, pass1_d;
  digest_t           pass2_q, pass2_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  word_t             hash_count_q, hash_count_d;
  logic              found_q, found_d;
  word_t             found_nonce_q, found_nonce_d;
  digest_t           found_hash_q, found_hash_d;

  digest_t sha_digest;
  block_t  sha_block;
  digest_t sha_out;
  logic    pass_last;
  logic    match;

  // Compressor input mux: PASS1 hashes the header tail, everything else the PASS1 digest.
  always_comb begin
    sha_digest = H_INIT;
    sha_block  = '0;
    if (state_q == ST_PASS1) begin
      sha_digest    = cfg_q.midstate;
      sha_block[0]  = cfg_q.merkle_tail;
      sha_block[1]  = cfg_q.timestamp;
      sha_block[2]  = cfg_q.target_bits;
      sha_block[3]  = bswap32(nonce_q);
      sha_block[4]  = PAD_ONE;
      sha_block[15] = LEN_PASS1;
    end else begin
      for (int i = 0; i < 8; i++) sha_block[i] = pass1_q[i];
      sha_block[8]  = PAD_ONE;
      sha_block[15] = LEN_PASS2;
    end
  end

  sha256_block u_sha (
    .digest_in  (sha_digest),
    .block_in   (sha_block),
    .digest_out (sha_out)
  );

  assign pass_last = (wait_q == WAIT_W'(SHA_WAIT));
  assign match     = (bswap32(pass2_q[7]) <= cfg_q.target_hi);

  // Next-state and datapath update for the scan FSM.
  always_comb begin
    // NOTE: every _d gets its hold value first so no branch can leave one unassigned and infer a latch.
    state_d       = state_q;
    cfg_d         = cfg_q;
    nonce_d       = nonce_q;
    pass1_d       = pass1_q;
    pass2_d       = pass2_q;
    wait_d        = wait_q;
    hash_count_d  = hash_count_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          cfg_d = '{midstate:    bus.midstate,
                    merkle_tail: bus.merkle_tail,
                    timestamp:   bus.timestamp,
                    target_bits: bus.target_bits,
                    nonce_end:   bus.nonce_end,
                    target_hi:   bus.target_hi};
          nonce_d      = bus.nonce_start;
          hash_count_d = '0;
          found_d      = 1'b0;
          wait_d       = '0;
          state_d      = ST_PASS1;
        end
      end
      ST_PASS1: begin
        if (bus.abort) begin
          found_d = 1'b0;
          state_d = ST_DONE;
        end else if (pass_last) begin
          pass1_d = sha_out;
          wait_d  = '0;
          state_d = ST_PASS2;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_PASS2: begin
        if (bus.abort) begin
          found_d = 1'b0;
          state_d = ST_DONE;
        end else if (pass_last) begin
          pass2_d = sha_out;
          wait_d  = '0;
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (bus.abort) begin
          found_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          hash_count_d = hash_count_q + 32'd1;
          if (match) begin
            found_d       = 1'b1;
            found_nonce_d = nonce_q;
            found_hash_d  = pass2_q;
            state_d       = ST_DONE;
          end else if (nonce_q == cfg_q.nonce_end) begin
            found_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            nonce_d = nonce_q + 32'd1;
            state_d = ST_PASS1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples its _d from before this edge.
    if (rst) begin
      state_q       <= ST_IDLE;
      cfg_q         <= '0;
      nonce_q       <= '0;
      pass1_q       <= '0;
      pass2_q       <= '0;
      wait_q        <= '0;
      hash_count_q  <= '0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      nonce_q       <= nonce_d;
      pass1_q       <= pass1_d;
      pass2_q       <= pass2_d;
      wait_q        <= wait_d;
      hash_count_q  <= hash_count_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
    end
  end

  assign bus.busy        = (state_q == ST_PASS1) || (state_q == ST_PASS2) || (state_q == ST_CHECK);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.found       = found_q;
  assign bus.found_nonce = found_nonce_q;
  assign bus.found_hash  = found_hash_q;
  assign bus.hash_count  = hash_count_q;

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Directed bench for sha256_nonce_sched built around the Bitcoin genesis header.
module tb_sha256_nonce_sched;
  import sha256_nonce_sched_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;
  digest_t genesis_mid;
  digest_t genesis_hash;

  sha256_nonce_sched_if bus0 ();
  sha256_nonce_sched_if bus1 ();

  sha256_nonce_sched #(.SHA_WAIT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sha256_nonce_sched #(.SHA_WAIT(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic word_t tb_rotr(word_t x, int unsigned s);
    return (x >> s) | (x << (32 - s));
  endfunction

  // Independent SHA-256 of the first 64 header bytes (version, zero prev hash, merkle head).
  function automatic digest_t tb_midstate();
    word_t w [64];
    word_t a, b, c, d, e, f, g, h, t1, t2;
    digest_t r;
    for (int i = 0; i < 16; i++) w[i] = '0;
    w[0]  = 32'h01000000;
    w[9]  = 32'h3ba3edfd; w[10] = 32'h7a7b12b2; w[11] = 32'h7ac72c3e;
    w[12] = 32'h67768f61; w[13] = 32'h7fc81bc3; w[14] = 32'h888a5132;
    w[15] = 32'h3a9fb8aa;
    for (int i = 16; i < 64; i++) begin
      w[i] = w[i-16] + w[i-7]
           + (tb_rotr(w[i-15], 7) ^ tb_rotr(w[i-15], 18) ^ (w[i-15] >> 3))
           + (tb_rotr(w[i-2], 17) ^ tb_rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    end
    a = H_INIT[0]; b = H_INIT[1]; c = H_INIT[2]; d = H_INIT[3];
    e = H_INIT[4]; f = H_INIT[5]; g = H_INIT[6]; h = H_INIT[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (tb_rotr(e, 6) ^ tb_rotr(e, 11) ^ tb_rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (tb_rotr(a, 2) ^ tb_rotr(a, 13) ^ tb_rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = H_INIT[0] + a; r[1] = H_INIT[1] + b; r[2] = H_INIT[2] + c; r[3] = H_INIT[3] + d;
    r[4] = H_INIT[4] + e; r[5] = H_INIT[5] + f; r[6] = H_INIT[6] + g; r[7] = H_INIT[7] + h;
    return r;
  endfunction

  task automatic set_cfg0(input word_t ns, input word_t ne, input word_t th);
    bus0.midstate    = genesis_mid;
    bus0.merkle_tail = 32'h4b1e5e4a;
    bus0.timestamp   = 32'h29ab5f49;
    bus0.target_bits = 32'hffff001d;
    bus0.nonce_start = ns;
    bus0.nonce_end   = ne;
    bus0.target_hi   = th;
  endtask

  // Called at a falling edge; pulses start on bus0 across one rising edge.
  task automatic pulse_start0();
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
  endtask

  // Counts falling edges until done is seen, bounded by budget.
  task automatic wait_done(input bit sel1, input int budget, output int cycles);
    cycles = 0;
    while (!(sel1 ? bus1.done : bus0.done) && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    genesis_hash = {32'h00000000, 32'h68d61900, 32'he15a089c, 32'h931e8365,
                    32'hae63f74f, 32'hc1a6a246, 32'hb6f1b372, 32'h6fe28c0a};
    genesis_mid  = tb_midstate();
    rst = 1'b1;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    set_cfg0(32'h7c2bac10, 32'h7c2bac2f, 32'h0);
    bus1.midstate = genesis_mid; bus1.merkle_tail = 32'h4b1e5e4a;
    bus1.timestamp = 32'h29ab5f49; bus1.target_bits = 32'hffff001d;
    bus1.nonce_start = 32'h0000_0100; bus1.nonce_end = 32'h0000_0200;
    bus1.target_hi = 32'hffff_ffff;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_done", bus0.done, 1'b0);
    check("rst_found", bus0.found, 1'b0);
    check("rst_hash_count", bus0.hash_count, 32'd0);
    check("rst_found_hash", bus0.found_hash, '0);

    // Genesis scan; start lands on the first edge after rst falls.
    rst = 1'b0;
    pulse_start0();
    check("gen_busy", bus0.busy, 1'b1);
    wait_done(1'b0, 200, n);
    check("gen_cycles", n, 42);
    check("gen_found", bus0.found, 1'b1);
    check("gen_nonce", bus0.found_nonce, 32'h7c2bac1d);
    check("gen_hash", bus0.found_hash, genesis_hash);
    check("gen_count", bus0.hash_count, 32'd14);
    check("gen_idle", bus0.busy, 1'b0);

    // Abort in DONE is ignored.
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    check("dabort_done", bus0.done, 1'b1);
    check("dabort_found", bus0.found, 1'b1);

    // Start with abort in DONE: start wins; later start and input changes are ignored.
    set_cfg0(32'h7c2bac1e, 32'h7c2bac2f, 32'h0);
    bus0.abort = 1'b1;
    pulse_start0();
    bus0.abort = 1'b0;
    check("rs_busy", bus0.busy, 1'b1);
    check("rs_done", bus0.done, 1'b0);
    check("rs_found", bus0.found, 1'b0);
    check("rs_count", bus0.hash_count, 32'd0);
    repeat (9) @(negedge clk);
    set_cfg0(32'h7c2bac1d, 32'h7c2bac1d, 32'hffff_ffff);
    pulse_start0();
    wait_done(1'b0, 200, n);
    check("miss_cycles", n + 10, 54);
    check("miss_found", bus0.found, 1'b0);
    check("miss_count", bus0.hash_count, 32'd18);

    // Range wrapping through 0xFFFFFFFF.
    set_cfg0(32'hffff_fffe, 32'h0000_0001, 32'h0);
    pulse_start0();
    check("wrap_n0", u_dut0.nonce_q, 32'hffff_fffe);
    repeat (3) @(negedge clk);
    check("wrap_n1", u_dut0.nonce_q, 32'hffff_ffff);
    repeat (3) @(negedge clk);
    check("wrap_n2", u_dut0.nonce_q, 32'h0000_0000);
    repeat (3) @(negedge clk);
    check("wrap_n3", u_dut0.nonce_q, 32'h0000_0001);
    wait_done(1'b0, 200, n);
    check("wrap_cycles", n + 9, 12);
    check("wrap_count", bus0.hash_count, 32'd4);
    check("wrap_found", bus0.found, 1'b0);

    // Accept-all threshold: first nonce wins.
    set_cfg0(32'h1234_5678, 32'h1234_5700, 32'hffff_ffff);
    pulse_start0();
    wait_done(1'b0, 200, n);
    check("all_cycles", n, 3);
    check("all_found", bus0.found, 1'b1);
    check("all_nonce", bus0.found_nonce, 32'h1234_5678);
    check("all_count", bus0.hash_count, 32'd1);

    // Same with SHA_WAIT=2.
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    wait_done(1'b1, 200, n);
    check("w2_cycles", n, 7);
    check("w2_found", bus1.found, 1'b1);
    check("w2_nonce", bus1.found_nonce, 32'h0000_0100);

    // Abort during PASS2 of the fifth nonce.
    set_cfg0(32'h7c2bac10, 32'h7c2bac2f, 32'h0);
    pulse_start0();
    repeat (13) @(negedge clk);
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    check("abort_done", bus0.done, 1'b1);
    check("abort_busy", bus0.busy, 1'b0);
    check("abort_found", bus0.found, 1'b0);
    check("abort_count", bus0.hash_count, 32'd4);

    // Asynchronous reset mid-scan.
    pulse_start0();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", bus0.busy, 1'b0);
    check("arst_done", bus0.done, 1'b0);
    check("arst_found_nonce", bus0.found_nonce, 32'd0);
    check("arst_found_hash", bus0.found_hash, '0);
    check("arst_count", bus0.hash_count, 32'd0);
    check("arst_nonce", u_dut0.nonce_q, 32'd0);
    check("arst_w2_found", bus1.found, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", bus0.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
